// File: rtl/pipe_stage_reg.sv
//----------------------------------------------------------------------------
// Module   : pipe_stage_reg
// Brief    : Skid-buffered pipeline stage register; in_ready is registered.
//            Optional macro PIPE_STAGE_STATS_EN adds stall/flush counters.
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module pipe_stage_reg #(
  parameter int          DATA_W    = 165,
  parameter logic [31:0] BUBBLE_PC = 32'h00003000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_pc
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_main_data;
  logic [31:0]       r_main_pc;
  logic [DATA_W-1:0] r_skid_data;
  logic [31:0]       r_skid_pc;

  logic w_accept;
  logic w_consume;
  logic w_main_clr;
  logic w_main_ld_in;
  logic w_main_ld_skid;
  logic w_skid_clr;
  logic w_skid_ld;

  assign w_accept  = in_valid & r_in_ready;
  assign w_consume = out_valid & out_ready;

  // State register; in_ready is derived from the next state so it never
  // depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_SKID);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) w_state_nxt = ST_FULL;
        end
        ST_FULL: begin
          if (w_accept && !w_consume)      w_state_nxt = ST_SKID;
          else if (!w_accept && w_consume) w_state_nxt = ST_EMPTY;
        end
        ST_SKID: begin
          if (w_consume) w_state_nxt = ST_FULL;
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_main_clr     = 1'b0;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_skid_clr     = 1'b0;
    w_skid_ld      = 1'b0;
    out_valid      = (r_state == ST_FULL) || (r_state == ST_SKID);
    in_ready       = r_in_ready;
    out_data       = r_main_data;
    out_pc         = r_main_pc;
    if (flush) begin
      w_main_clr = 1'b1;
      w_skid_clr = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          w_main_ld_in = w_accept;
        end
        ST_FULL: begin
          if (w_accept && w_consume) w_main_ld_in = 1'b1;
          else if (w_consume)        w_main_clr   = 1'b1;
          else if (w_accept)         w_skid_ld    = 1'b1;
        end
        ST_SKID: begin
          if (w_consume) begin
            w_main_ld_skid = 1'b1;
            w_skid_clr     = 1'b1;
          end
        end
        default: begin
          w_main_clr = 1'b1;
          w_skid_clr = 1'b1;
        end
      endcase
    end
  end

  // The main register is cleared whenever the stage empties, so the outputs
  // show nop/BUBBLE_PC directly without a mux and ignore in_data/in_pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_data <= '0;
      r_main_pc   <= BUBBLE_PC;
      r_skid_data <= '0;
      r_skid_pc   <= '0;
    end else begin
      if (w_main_clr) begin
        r_main_data <= '0;
        r_main_pc   <= BUBBLE_PC;
      end else if (w_main_ld_in) begin
        r_main_data <= in_data;
        r_main_pc   <= in_pc;
      end else if (w_main_ld_skid) begin
        r_main_data <= r_skid_data;
        r_main_pc   <= r_skid_pc;
      end

      if (w_skid_clr) begin
        r_skid_data <= '0;
        r_skid_pc   <= '0;
      end else if (w_skid_ld) begin
        r_skid_data <= in_data;
        r_skid_pc   <= in_pc;
      end
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
//----------------------------------------------------------------------------
// Module   : tb_pipe_stage_reg
// Brief    : Directed self-checking bench for pipe_stage_reg.
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_reg;

  localparam int          DATA_W = 165;
  localparam logic [31:0] BPC    = 32'h00003000;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [31:0]       in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [31:0]       out_pc;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]       stall_cnt;
  logic [15:0]       flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .BUBBLE_PC(BPC)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_pc    (out_pc)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Payload is a fixed pattern of the PC, so each entry is identifiable.
  function automatic logic [DATA_W-1:0] pay(input logic [31:0] pc);
    logic [191:0] t;
    t = {pc, ~pc, pc, ~pc, pc, ~pc};
    return t[DATA_W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic [DATA_W-1:0] d, input logic rdy);
    chk({tag, ".valid"}, 192'(out_valid), 192'(v));
    chk({tag, ".pc"},    192'(out_pc),    192'(pc));
    chk({tag, ".data"},  192'(out_data),  192'(d));
    chk({tag, ".ready"}, 192'(in_ready),  192'(rdy));
  endtask

  task automatic push(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_data  = pay(pc);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = DATA_W'(5); in_pc = 32'h1234;
    tick(); tick();
    reset = 1'b0;
    chk_out("reset", 1'b0, BPC, '0, 1'b1);
    in_valid = 1'b0;

    // Streaming with downstream always ready
    out_ready = 1'b1;
    push(32'h3000); tick(); chk_out("str0", 1'b1, 32'h3000, pay(32'h3000), 1'b1);
    push(32'h3004); tick(); chk_out("str1", 1'b1, 32'h3004, pay(32'h3004), 1'b1);
    push(32'h3008); tick(); chk_out("str2", 1'b1, 32'h3008, pay(32'h3008), 1'b1);
    in_valid = 1'b0; tick();
    chk_out("str_drain", 1'b0, BPC, '0, 1'b1);

    // Idle input changes must not leak to the outputs
    in_pc = 32'hDEAD_BEEF; in_data = pay(32'hDEAD_BEEF); tick();
    chk_out("idle", 1'b0, BPC, '0, 1'b1);

    // Backpressure into the skid register
    out_ready = 1'b0;
    push(32'h3000); tick(); chk_out("bp_full", 1'b1, 32'h3000, pay(32'h3000), 1'b1);
    push(32'h3004); tick(); chk_out("bp_skid", 1'b1, 32'h3000, pay(32'h3000), 1'b0);
    push(32'h3010); tick(); chk_out("bp_hold", 1'b1, 32'h3000, pay(32'h3000), 1'b0);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk_out("bp_pop1", 1'b1, 32'h3004, pay(32'h3004), 1'b1);
    tick();
    chk_out("bp_pop2", 1'b0, BPC, '0, 1'b1);

    // Flush while in SKID with an offered entry
    out_ready = 1'b0;
    push(32'h3000); tick();
    push(32'h3004); tick();
    chk("fl_pre_ready", 192'(in_ready), 192'(1'b0));
    flush = 1'b1; push(32'h300C); tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_out("flush_skid", 1'b0, BPC, '0, 1'b1);
    out_ready = 1'b1; tick();
    chk_out("flush_after", 1'b0, BPC, '0, 1'b1);

    // Flush in FULL discards a same-cycle accept
    out_ready = 1'b0;
    push(32'h3014); tick();
    flush = 1'b1; push(32'h3020); tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_out("flush_full", 1'b0, BPC, '0, 1'b1);
    tick();
    chk_out("flush_full2", 1'b0, BPC, '0, 1'b1);

    // Reset mid-operation beats flush and handshakes
    push(32'h3030); tick();
    push(32'h3034); tick();
    reset = 1'b1; flush = 1'b1; out_ready = 1'b1; push(32'h3038); tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk_out("rst_mid", 1'b0, BPC, '0, 1'b1);
    tick();
    chk_out("rst_mid2", 1'b0, BPC, '0, 1'b1);

`ifdef PIPE_STAGE_STATS_EN
    reset = 1'b1; tick(); reset = 1'b0;
    out_ready = 1'b0;
    push(32'h3040); tick();
    in_valid = 1'b0;
    repeat (7) tick();
    out_ready = 1'b1; flush = 1'b1;
    repeat (2) tick();
    flush = 1'b0;
    chk("stall_cnt", 192'(stall_cnt), 192'(32'd7));
    chk("flush_cnt", 192'(flush_cnt), 192'(16'd2));
    reset = 1'b1; tick(); reset = 1'b0;
    chk("stall_rst", 192'(stall_cnt), 192'(32'd0));
    chk("flush_rst", 192'(flush_cnt), 192'(16'd0));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 165, width of the stage payload (instruction, operands, immediate, write address).
REQ-002 Parameter BUBBLE_PC, default 32'h00003000, PC value presented while the stage holds no valid entry.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port flush  input  1  synchronous clear of all held entries (branch/exception squash).
REQ-006 Port in_valid  input  1  upstream offers an entry.
REQ-007 Port in_ready  output  1  stage accepts an entry this cycle; driven only from a register, with no combinational path from out_ready.
REQ-008 Port in_data  input  DATA_W  upstream payload.
REQ-009 Port in_pc  input  32  upstream PC.
REQ-010 Port out_valid  output  1  stage presents a valid entry.
REQ-011 Port out_ready  input  1  downstream consumes the entry this cycle.
REQ-012 Port out_data  output  DATA_W  presented payload; all zeros (nop) when out_valid=0.
REQ-013 Port out_pc  output  32  presented PC; BUBBLE_PC when out_valid=0.

Function
REQ-014 Storage SHALL consist of a main register and a skid register; state SHALL be EMPTY, FULL (main only) or SKID (main and skid).
REQ-015 Handshakes: accept = in_valid & in_ready; consume = out_valid & out_ready.
REQ-016 Transition EMPTY->FULL on accept; the entry SHALL be presented on the next cycle (1-cycle latency).
REQ-017 In FULL: accept & consume loads main with the new entry and stays FULL; consume only goes to EMPTY; accept only stores the entry in skid and goes to SKID; neither holds state.
REQ-018 In SKID: in_ready=0; consume moves skid to main and goes to FULL; otherwise hold.
REQ-019 in_ready SHALL be 1 in EMPTY and FULL and 0 in SKID; the next-cycle value SHALL be computed from the registered state.
REQ-020 Entries SHALL leave in acceptance order; none dropped or duplicated absent flush.
REQ-021 flush SHALL have priority over all handshakes: next state EMPTY, any same-cycle accept discarded, and out_data/out_pc forced to zero/BUBBLE_PC on the next cycle.
REQ-022 While out_valid=0, out_data and out_pc SHALL not change in response to in_data/in_pc.

Reset
REQ-023 On reset: state EMPTY, out_valid=0, out_data=0, out_pc=BUBBLE_PC, in_ready=1 on the following cycle; skid contents zeroed.
REQ-024 Reset asserted mid-operation SHALL discard both entries in one cycle, taking priority over flush and handshakes.

Configuration
REQ-025 Macro PIPE_STAGE_STATS_EN: when defined, add outputs stall_cnt (32, cycles with out_valid & !out_ready) and flush_cnt (16, cycles with flush=1); both are cleared by reset and saturate at all-ones.
REQ-026 When PIPE_STAGE_STATS_EN is undefined, neither port nor counter logic SHALL exist; all other behaviour is identical.

Verification
REQ-027 Reset with in_valid=1 and in_data=5 -> cycle after reset release: out_valid=0, out_pc=32'h00003000, out_data=0, in_ready=1.
REQ-028 Stream PCs 0x3000, 0x3004, 0x3008 with out_ready=1 -> each appears exactly 1 cycle after accept, in order, in_ready constantly 1.
REQ-029 out_ready=0 while pushing 0x3000 then 0x3004 -> state SKID, in_ready=0, out_pc holds 0x3000; raising out_ready yields 0x3000 then 0x3004 on consecutive cycles.
REQ-030 In SKID, assert flush with in_valid=1 and in_pc=0x300C -> next cycle out_valid=0, out_pc=0x3000 (BUBBLE_PC), in_ready=1, 0x300C never emerges.
REQ-031 With PIPE_STAGE_STATS_EN defined: 7 stalled cycles and 2 flush cycles -> stall_cnt=7, flush_cnt=2; reset returns both to 0.
